// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel operand loader: assembles WIDTH serial bits into a word for the
// shifter D input, holding each word until the consumer takes it.
module serial_nibble_loader #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   input  logic             sof,
   output logic             bit_ready,
   output logic [WIDTH-1:0] d_out,
   output logic             d_valid,
   input  logic             d_ready,
   output logic             resync_err,
   output logic [7:0]       word_cnt
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             err_q, err_d;
   logic [7:0]       wcnt_q, wcnt_d;

   logic             accept;
   logic             xfer;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                 input logic b);
      if (MSB_FIRST != 0) return {sr[WIDTH-2:0], b};
      else                return {b, sr[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= COLLECT;
         cnt_q   <= '0;
         sr_q    <= '0;
         dout_q  <= '0;
         err_q   <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign accept = bit_valid && bit_ready;
   assign xfer   = (state_q == HOLD) && d_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      dout_d  = dout_q;
      err_d   = 1'b0;
      wcnt_d  = wcnt_q;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               if (sof) begin
                  // sof always restarts the word; a partial word being dropped is an error
                  sr_d  = shift_in('0, bit_in);
                  cnt_d = CNT_ONE;
                  err_d = (cnt_q != '0);
               end else if (cnt_q == CNT_LAST) begin
                  sr_d    = shift_in(sr_q, bit_in);
                  dout_d  = shift_in(sr_q, bit_in);
                  cnt_d   = '0;
                  state_d = HOLD;
               end else begin
                  sr_d  = shift_in(sr_q, bit_in);
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (xfer) begin
               wcnt_d  = wcnt_q + 8'd1;
               state_d = COLLECT;
               // a bit arriving with the transfer starts the next word without a bubble
               if (accept) begin
                  sr_d  = shift_in('0, bit_in);
                  cnt_d = CNT_ONE;
               end
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_comb begin
      bit_ready = 1'b1;
      d_valid   = 1'b0;
      if (state_q == HOLD) begin
         bit_ready = d_ready;
         d_valid   = 1'b1;
      end
   end

   assign d_out      = dout_q;
   assign resync_err = err_q;
   assign word_cnt   = wcnt_q;

endmodule
